fp_std_1: RTL and testbench
===========================

FP_STD_1 -- requirements
Module: fp_std_1

Interface
REQ-001 SHALL have parameter WIDTH, default 24, meaning operand/result width in 1/8/15 format (sign, biased-127 exponent, fraction).
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port valid_i  input  1  upstream stage-0 outputs are valid this cycle.
REQ-005 SHALL have port ready_o  output  1  block accepts a transaction when valid_i && ready_o.
REQ-006 SHALL have port op_i  input  4  op delayed to match stage 0; [1:0] 00 add/sub, 01 min, 10 max, 11 reserved (treated as add/sub).
REQ-007 SHALL have ports add_mant_i  input  17 and sub_mant_i  input  16  aligned magnitude sum and difference.
REQ-008 SHALL have ports max_sign_i, min_sign_i  input  1 each  effective signs of the larger and smaller magnitudes.
REQ-009 SHALL have port max_exp_i  input  8  exponent of the larger magnitude.
REQ-010 SHALL have ports max_res_i, min_res_i  input  WIDTH each  signed max/min operands.
REQ-011 SHALL have port valid_o  output  1  result_o valid.
REQ-012 SHALL have port ready_i  input  1  downstream accepts when valid_o && ready_i.
REQ-013 SHALL have port result_o  output  WIDTH  normalized result.
REQ-014 SHALL have ports ovf_o, zero_o  output  1 each  result saturated to infinity / result is zero.

Function
REQ-015 SHALL be a 2-entry pipeline: stage A (capture, effective-op select, leading-zero count), stage B (shift, exponent adjust, pack); latency exactly 2 cycles with no stall.
REQ-016 Each stage SHALL advance when its successor is empty or advancing; ready_o = !A_valid || A_advance; A_advance = !B_valid || ready_i.
REQ-017 With ready_i low and both stages full, ready_o SHALL be 0, and result_o, valid_o, ovf_o, zero_o SHALL hold stable.
REQ-018 Simultaneous accept and output handshake in one cycle SHALL sustain 1 result/cycle without loss or duplication.
REQ-019 op min/max: result SHALL be min_res_i / max_res_i unmodified; ovf_o=0; zero_o=1 only if exponent and fraction are 0.
REQ-020 Effective add (max_sign_i==min_sign_i): if add_mant_i[16], fraction = add_mant_i[15:1], exponent = max_exp_i+1; else fraction = add_mant_i[14:0], exponent = max_exp_i.
REQ-021 Effective subtract (signs differ): lzc = leading-zero count of sub_mant_i (0..15); fraction = (sub_mant_i<<lzc)[14:0]; exponent = max_exp_i-lzc.
REQ-022 Rounding SHALL be truncation; bits shifted out are discarded.
REQ-023 Result sign SHALL be max_sign_i, except exact zero from subtract SHALL be +0.
REQ-024 sub_mant_i==0 on subtract SHALL give result 0, zero_o=1.
REQ-025 Subtract with lzc >= max_exp_i (underflow) SHALL flush to signed zero {max_sign_i,0}; zero_o=1.
REQ-026 max_exp_i==0 (both denormal/zero) SHALL flush to signed zero; zero_o=1.
REQ-027 max_exp_i==255 or computed exponent >=255 SHALL give {sign,8'hFF,15'b0}; ovf_o=1 only when computed from a finite max_exp_i; NaN is not distinguished from infinity.
REQ-028 Exponent arithmetic SHALL use 10-bit signed intermediates; no wrap-around.

Reset
REQ-029 On rst_ni low, both stage valids SHALL clear asynchronously; valid_o=0, result_o=0, ovf_o=0, zero_o=0; ready_o=1 out of reset.
REQ-030 Reset asserted mid-operation SHALL discard in-flight transactions; nothing emitted after release until new valid_i.

Verification
REQ-031 1.0+1.0: add_mant_i=17'h10000, max_exp_i=127, signs 0 -> after 2 cycles result_o=24'h400000, ovf_o=0.
REQ-032 1.5-1.0: sub_mant_i=16'h4000, max_exp_i=127, max_sign_i=0, min_sign_i=1 -> result_o=24'h3F0000.
REQ-033 1.0-1.0: sub_mant_i=0, signs differ -> result_o=24'h000000, zero_o=1.
REQ-034 Overflow: add_mant_i=17'h10000, max_exp_i=254, signs 0 -> result_o=24'h7F8000, ovf_o=1.
REQ-035 Backpressure: 3 back-to-back valid_i with ready_i=0 -> ready_o=0 on 3rd; after ready_i=1, all 3 results in order, none lost.
REQ-036 Reset mid-flight: 2 accepted, rst_ni pulsed low -> valid_o=0 immediately; no stale result after release.

Source files
------------

// File: rtl/fp_std_1.sv
`default_nettype none
// ============================================================================
// Module   : fp_std_1
// Purpose  : Two-stage floating-point normalize/pack pipeline (1/8/15 format)
//            with valid/ready handshaking on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module fp_std_1 #(
    parameter int WIDTH = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       op_i,
    input  logic [16:0]      add_mant_i,
    input  logic [15:0]      sub_mant_i,
    input  logic             max_sign_i,
    input  logic             min_sign_i,
    input  logic [7:0]       max_exp_i,
    input  logic [WIDTH-1:0] max_res_i,
    input  logic [WIDTH-1:0] min_res_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o,
    output logic             zero_o
);

    localparam logic [1:0] c_KIND_ADD = 2'd0;
    localparam logic [1:0] c_KIND_SUB = 2'd1;
    localparam logic [1:0] c_KIND_MIN = 2'd2;
    localparam logic [1:0] c_KIND_MAX = 2'd3;

    // Position of the most significant set bit, expressed as a left-shift amount.
    function automatic logic [3:0] f_lzc16(input logic [15:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) n = 4'(15 - i);
        end
        return n;
    endfunction

    logic             r_a_valid;
    logic [1:0]       r_a_kind;
    logic             r_a_sign;
    logic [7:0]       r_a_exp;
    logic [16:0]      r_a_mant;
    logic [3:0]       r_a_lzc;
    logic [WIDTH-1:0] r_a_res;
    logic             r_b_valid;

    logic             w_a_adv;
    logic             w_accept;
    logic [1:0]       w_kind;
    logic [9:0]       w_exp_base;
    logic [9:0]       w_exp_add;
    logic [9:0]       w_exp_sub;
    logic [14:0]      w_frac_add;
    logic [15:0]      w_sub_shift;
    logic [WIDTH-1:0] w_b_res;
    logic             w_b_ovf;
    logic             w_b_zero;
    logic             w_unused;

    assign w_a_adv  = !r_b_valid || ready_i;
    assign ready_o  = !r_a_valid || w_a_adv;
    assign w_accept = valid_i && ready_o;
    assign valid_o  = r_b_valid;

    // Reserved op 2'b11 falls through to add/sub.
    always_comb begin
        w_kind = (max_sign_i == min_sign_i) ? c_KIND_ADD : c_KIND_SUB;
        case (op_i[1:0])
            2'b01:   w_kind = c_KIND_MIN;
            2'b10:   w_kind = c_KIND_MAX;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a_valid <= 1'b0;
            r_a_kind  <= c_KIND_ADD;
            r_a_sign  <= 1'b0;
            r_a_exp   <= 8'd0;
            r_a_mant  <= 17'd0;
            r_a_lzc   <= 4'd0;
            r_a_res   <= '0;
        end else begin
            if (w_accept) begin
                r_a_valid <= 1'b1;
            end else if (w_a_adv) begin
                r_a_valid <= 1'b0;
            end
            if (w_accept) begin
                r_a_kind <= w_kind;
                r_a_sign <= max_sign_i;
                r_a_exp  <= max_exp_i;
                r_a_mant <= (w_kind == c_KIND_SUB) ? {1'b0, sub_mant_i} : add_mant_i;
                r_a_lzc  <= f_lzc16(sub_mant_i);
                r_a_res  <= (w_kind == c_KIND_MIN) ? min_res_i : max_res_i;
            end
        end
    end

    // Exponent math is done 10-bit signed so carry-out and underflow never wrap.
    assign w_exp_base  = {2'b00, r_a_exp};
    assign w_exp_add   = w_exp_base + (r_a_mant[16] ? 10'd1 : 10'd0);
    assign w_exp_sub   = w_exp_base - {6'd0, r_a_lzc};
    assign w_frac_add  = r_a_mant[16] ? r_a_mant[15:1] : r_a_mant[14:0];
    assign w_sub_shift = r_a_mant[15:0] << r_a_lzc;

    always_comb begin
        w_b_res  = '0;
        w_b_ovf  = 1'b0;
        w_b_zero = 1'b0;
        if ((r_a_kind == c_KIND_MIN) || (r_a_kind == c_KIND_MAX)) begin
            w_b_res  = r_a_res;
            w_b_zero = (r_a_res[WIDTH-2:0] == '0);
        end else if (r_a_exp == 8'hFF) begin
            w_b_res = WIDTH'({r_a_sign, 8'hFF, 15'd0});
        end else if (r_a_exp == 8'd0) begin
            w_b_res  = WIDTH'({r_a_sign, 23'd0});
            w_b_zero = 1'b1;
        end else if (r_a_kind == c_KIND_ADD) begin
            if ($signed(w_exp_add) >= 10'sd255) begin
                w_b_res = WIDTH'({r_a_sign, 8'hFF, 15'd0});
                w_b_ovf = 1'b1;
            end else begin
                w_b_res = WIDTH'({r_a_sign, w_exp_add[7:0], w_frac_add});
            end
        end else if (r_a_mant[15:0] == 16'd0) begin
            w_b_zero = 1'b1;
        end else if ($signed(w_exp_sub) <= 10'sd0) begin
            w_b_res  = WIDTH'({r_a_sign, 23'd0});
            w_b_zero = 1'b1;
        end else begin
            w_b_res = WIDTH'({r_a_sign, w_exp_sub[7:0], w_sub_shift[14:0]});
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_b_valid <= 1'b0;
            result_o  <= '0;
            ovf_o     <= 1'b0;
            zero_o    <= 1'b0;
        end else if (w_a_adv) begin
            r_b_valid <= r_a_valid;
            if (r_a_valid) begin
                result_o <= w_b_res;
                ovf_o    <= w_b_ovf;
                zero_o   <= w_b_zero;
            end
        end
    end

    assign w_unused = &{1'b0, op_i[3:2], w_sub_shift[15], w_exp_add[9:8], w_exp_sub[9:8]};

endmodule
`default_nettype wire

// File: tb/tb_fp_std_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_std_1
// Purpose  : Directed + randomized scoreboard bench for fp_std_1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_std_1;

    typedef struct packed {
        logic [23:0] res;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  op_i;
    logic [16:0] add_mant_i;
    logic [15:0] sub_mant_i;
    logic        max_sign_i;
    logic        min_sign_i;
    logic [7:0]  max_exp_i;
    logic [23:0] max_res_i;
    logic [23:0] min_res_i;
    logic        valid_o;
    logic        ready_i;
    logic [23:0] result_o;
    logic        ovf_o;
    logic        zero_o;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    fp_std_1 #(.WIDTH(24)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .op_i       (op_i),
        .add_mant_i (add_mant_i),
        .sub_mant_i (sub_mant_i),
        .max_sign_i (max_sign_i),
        .min_sign_i (min_sign_i),
        .max_exp_i  (max_exp_i),
        .max_res_i  (max_res_i),
        .min_res_i  (min_res_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o),
        .ovf_o      (ovf_o),
        .zero_o     (zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic exp_t mk(input logic [23:0] r, input logic o, input logic z);
        return {r, o, z};
    endfunction

    // Reference written in integer arithmetic, independent of the RTL structure.
    function automatic exp_t model();
        exp_t r;
        int   ex;
        int   m;
        int   sh;
        r = '0;
        if (op_i[1:0] == 2'b01) begin
            r.res = min_res_i; r.zero = (min_res_i[22:0] == 23'd0);
        end else if (op_i[1:0] == 2'b10) begin
            r.res = max_res_i; r.zero = (max_res_i[22:0] == 23'd0);
        end else if (max_exp_i == 8'hFF) begin
            r.res = {max_sign_i, 8'hFF, 15'd0};
        end else if (max_exp_i == 8'd0) begin
            r.res = {max_sign_i, 23'd0}; r.zero = 1'b1;
        end else if (max_sign_i == min_sign_i) begin
            ex = int'(max_exp_i);
            m  = int'(add_mant_i);
            if (m >= 65536) begin ex = ex + 1; m = m / 2; end
            if (ex >= 255) begin
                r.res = {max_sign_i, 8'hFF, 15'd0}; r.ovf = 1'b1;
            end else begin
                r.res = {max_sign_i, 8'(ex), 15'(m % 32768)};
            end
        end else begin
            m = int'(sub_mant_i);
            if (m == 0) begin
                r.zero = 1'b1;
            end else begin
                sh = 0;
                while (m < 32768) begin m = m * 2; sh++; end
                ex = int'(max_exp_i) - sh;
                if (ex <= 0) begin
                    r.res = {max_sign_i, 23'd0}; r.zero = 1'b1;
                end else begin
                    r.res = {max_sign_i, 8'(ex), 15'(m % 32768)};
                end
            end
        end
        return r;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [16:0] am, input logic [15:0] sm,
                         input logic smx, input logic smn, input logic [7:0] e,
                         input logic [23:0] mxr, input logic [23:0] mnr);
        op_i = op; add_mant_i = am; sub_mant_i = sm;
        max_sign_i = smx; min_sign_i = smn; max_exp_i = e;
        max_res_i = mxr; min_res_i = mnr;
    endtask

    task automatic rand_drive();
        logic [7:0] e;
        case ($urandom_range(0, 9))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'hFE;
            3:       e = 8'($urandom_range(1, 15));
            default: e = 8'($urandom_range(1, 254));
        endcase
        drive(4'($urandom), 17'($urandom), 16'($urandom >> $urandom_range(16, 31)),
              1'($urandom), 1'($urandom), e, 24'($urandom), 24'($urandom));
    endtask

    // Holds valid_i until accepted; returns the number of stalled cycles.
    task automatic handshake(input exp_t e, output int n);
        n = 0;
        valid_i = 1'b1;
        @(negedge clk);
        while (!ready_o && n < 50) begin
            @(posedge clk); #1;
            ready_i = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!ready_o) check("accept_timeout", 32'(ready_o), 32'd1);
        else q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        ready_i = 1'b1;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_ni && valid_o && ready_i) begin
            if (q.size() == 0) begin
                check("unexpected_output", 32'(valid_o), 32'd0);
            end else begin
                e = q.pop_front();
                check("result", 32'(result_o), 32'(e.res));
                check("ovf", 32'(ovf_o), 32'(e.ovf));
                check("zero", 32'(zero_o), 32'(e.zero));
            end
        end
    end

    initial begin : stim
        int   n;
        int   total;
        exp_t e1;
        exp_t e3;
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        drive(4'h0, 17'd0, 16'd0, 1'b0, 1'b0, 8'd0, 24'd0, 24'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_result", 32'(result_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        check("rst_zero", 32'(zero_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        rst_ni = 1'b1;

        // 1.0 + 1.0 with explicit two-cycle latency check
        drive(4'h0, 17'h10000, 16'h0, 1'b0, 1'b0, 8'd127, 24'd0, 24'd0);
        handshake(mk(24'h400000, 1'b0, 1'b0), n);
        valid_i = 1'b0;
        check("lat1_valid", 32'(valid_o), 32'd0);
        @(posedge clk); #1;
        check("lat2_valid", 32'(valid_o), 32'd1);
        check("lat2_result", 32'(result_o), 32'h400000);

        drive(4'h0, 17'h0, 16'h4000, 1'b0, 1'b1, 8'd127, 24'd0, 24'd0);
        handshake(mk(24'h3F0000, 1'b0, 1'b0), n);
        drive(4'h0, 17'h0, 16'h0000, 1'b0, 1'b1, 8'd127, 24'd0, 24'd0);
        handshake(mk(24'h000000, 1'b0, 1'b1), n);
        drive(4'h0, 17'h10000, 16'h0, 1'b0, 1'b0, 8'd254, 24'd0, 24'd0);
        handshake(mk(24'h7F8000, 1'b1, 1'b0), n);
        drive(4'h0, 17'h0, 16'h0001, 1'b1, 1'b0, 8'd10, 24'd0, 24'd0);
        handshake(mk(24'h800000, 1'b0, 1'b1), n);
        drive(4'h0, 17'h1ABCD, 16'h0, 1'b1, 1'b1, 8'd255, 24'd0, 24'd0);
        handshake(mk(24'hFF8000, 1'b0, 1'b0), n);
        drive(4'h0, 17'h08000, 16'h0, 1'b1, 1'b1, 8'd0, 24'd0, 24'd0);
        handshake(mk(24'h800000, 1'b0, 1'b1), n);
        drive(4'h0, 17'h0, 16'h1000, 1'b0, 1'b1, 8'd4, 24'd0, 24'd0);
        handshake(mk(24'h008000, 1'b0, 1'b0), n);
        drive(4'h0, 17'h0, 16'h1000, 1'b0, 1'b1, 8'd3, 24'd0, 24'd0);
        handshake(mk(24'h000000, 1'b0, 1'b1), n);
        drive(4'h0, 17'h0C000, 16'h0, 1'b1, 1'b1, 8'd100, 24'd0, 24'd0);
        handshake(mk(24'hB24000, 1'b0, 1'b0), n);
        drive(4'h0, 17'h18000, 16'h0, 1'b0, 1'b0, 8'd253, 24'd0, 24'd0);
        handshake(mk(24'h7F4000, 1'b0, 1'b0), n);
        drive(4'h1, 17'h1FFFF, 16'hFFFF, 1'b0, 1'b0, 8'd254, 24'h3F8000, 24'h800000);
        handshake(mk(24'h800000, 1'b0, 1'b1), n);
        drive(4'h2, 17'h1FFFF, 16'hFFFF, 1'b0, 1'b0, 8'd254, 24'h3F8000, 24'h800000);
        handshake(mk(24'h3F8000, 1'b0, 1'b0), n);
        drive(4'hF, 17'h0, 16'h8000, 1'b1, 1'b0, 8'd127, 24'd0, 24'd0);
        handshake(mk(24'hBF8000, 1'b0, 1'b0), n);
        valid_i = 1'b0;
        drain();

        // Backpressure: two accepted into a stalled pipe, third refused until ready_i
        ready_i = 1'b0;
        e1 = mk(24'h400000, 1'b0, 1'b0);
        e3 = mk(24'h000000, 1'b0, 1'b1);
        drive(4'h0, 17'h10000, 16'h0, 1'b0, 1'b0, 8'd127, 24'd0, 24'd0);
        handshake(e1, n);
        drive(4'h0, 17'h0, 16'h4000, 1'b0, 1'b1, 8'd127, 24'd0, 24'd0);
        handshake(mk(24'h3F0000, 1'b0, 1'b0), n);
        drive(4'h0, 17'h0, 16'h0000, 1'b0, 1'b1, 8'd127, 24'd0, 24'd0);
        valid_i = 1'b1;
        @(negedge clk);
        check("bp_ready_low", 32'(ready_o), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(valid_o), 32'd1);
            check("bp_hold_result", 32'(result_o), 32'(e1.res));
            check("bp_hold_ready", 32'(ready_o), 32'd0);
        end
        @(posedge clk); #1;
        ready_i = 1'b1;
        handshake(e3, n);
        valid_i = 1'b0;
        drain();

        // Back-to-back stream with ready_i high must never stall
        ready_i = 1'b1;
        total = 0;
        for (int i = 0; i < 24; i++) begin
            rand_drive();
            handshake(model(), n);
            total += n;
        end
        valid_i = 1'b0;
        check("throughput_stalls", 32'(total), 32'd0);
        drain();

        // Stream with random downstream backpressure
        for (int i = 0; i < 24; i++) begin
            ready_i = ($urandom_range(0, 2) != 0);
            rand_drive();
            handshake(model(), n);
        end
        valid_i = 1'b0;
        drain();

        // Reset while two transactions are in flight
        ready_i = 1'b0;
        drive(4'h0, 17'h10000, 16'h0, 1'b0, 1'b0, 8'd127, 24'd0, 24'd0);
        handshake(e1, n);
        drive(4'h0, 17'h0, 16'h0000, 1'b0, 1'b1, 8'd127, 24'd0, 24'd0);
        handshake(e3, n);
        valid_i = 1'b0;
        check("mid_valid_before_rst", 32'(valid_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_result", 32'(result_o), 32'd0);
        check("mid_rst_ready", 32'(ready_o), 32'd1);
        q.delete();
        @(posedge clk); #1;
        rst_ni = 1'b1;
        ready_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_no_stale", 32'(valid_o), 32'd0);

        drive(4'h0, 17'h0, 16'h4000, 1'b0, 1'b1, 8'd127, 24'd0, 24'd0);
        handshake(mk(24'h3F0000, 1'b0, 1'b0), n);
        valid_i = 1'b0;
        drain();
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
